// File: rtl/dedup_pkg.sv
// rtl/dedup_pkg.sv - shared defaults, count width helper and FSM state type for the dedup stream controller
package dedup_pkg;

   localparam int DEDUP_DATA_W = 8;
   localparam int DEDUP_N_ELEM = 9;

   // Width needed to hold a count of 0..n inclusive
   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

   typedef enum logic [1:0] {
      LOAD = 2'd0,
      SCAN = 2'd1,
      EMIT = 2'd2
   } state_t;

endpackage

// File: rtl/dedup_stream_ctrl_if.sv
// rtl/dedup_stream_ctrl_if.sv - input/output element stream handshake bundle for the dedup stream controller
interface dedup_stream_ctrl_if
   import dedup_pkg::*;
#(
   parameter int DATA_W = DEDUP_DATA_W
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_last;

   // Producer/consumer side that drives input elements and accepts output elements
   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_last
   );

   // Controller side
   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_last
   );
endinterface

// File: rtl/dedup_match.sv
// rtl/dedup_match.sv - combinational search of one candidate against the valid prefix of the keep list
module dedup_match
   import dedup_pkg::*;
#(
   parameter int DATA_W = DEDUP_DATA_W,
   parameter int N_ELEM = DEDUP_N_ELEM,
   parameter int CW     = cnt_w(DEDUP_N_ELEM)
) (
   input  logic [DATA_W-1:0]              cand,
   input  logic [(N_ELEM-1)*DATA_W-1:0]   keep_flat,
   input  logic [CW-1:0]                  kept_cnt,
   output logic                           hit
);

   // Only entries below kept_cnt hold real data; stale entries must never match
   always_comb begin
      hit = 1'b0;
      for (int i = 0; i < N_ELEM - 1; i++) begin
         if ((CW'(i) < kept_cnt) && (keep_flat[i*DATA_W +: DATA_W] == cand))
            hit = 1'b1;
      end
   end

endmodule

// File: rtl/dedup_stream_ctrl.sv
// rtl/dedup_stream_ctrl.sv - frame deduplicator (load, scan, emit unique elements); optional stats via DEDUP_STREAM_CTRL_STATS_EN
module dedup_stream_ctrl
   import dedup_pkg::*;
#(
   parameter int DATA_W = DEDUP_DATA_W,
   parameter int N_ELEM = DEDUP_N_ELEM,
   localparam int CW    = cnt_w(N_ELEM)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear,
   dedup_stream_ctrl_if.slave st,
   output logic [CW-1:0] unique_count,
   output logic          busy
`ifdef DEDUP_STREAM_CTRL_STATS_EN
   ,
   output logic [15:0]   frame_cnt,
   output logic [15:0]   dup_cnt
`endif
);

   state_t              state_q, state_d;
   logic [CW-1:0]       load_idx, scan_idx, emit_idx, kept_cnt;
   logic [DATA_W-1:0]   buf_mem  [N_ELEM];
   logic [DATA_W-1:0]   keep_mem [N_ELEM];
   logic [(N_ELEM-1)*DATA_W-1:0] keep_flat;
   logic [DATA_W-1:0]   cand;
   logic                ready_q;
   logic                hit, in_fire, out_fire, last_load, last_scan;

   // ready_q holds in_ready low through reset and for the first cycle after release
   assign st.in_ready  = ready_q && (state_q == LOAD);
   assign st.out_valid = (state_q == EMIT);
   assign st.out_data  = (state_q == EMIT) ? keep_mem[emit_idx] : '0;
   assign st.out_last  = (state_q == EMIT) && (emit_idx == unique_count - CW'(1));
   assign busy         = !((state_q == LOAD) && (load_idx == '0));

   // clear outranks any handshake in the same cycle
   assign in_fire   = st.in_valid && st.in_ready && !clear;
   assign out_fire  = st.out_valid && st.out_ready && !clear;
   assign last_load = (load_idx == CW'(N_ELEM - 1));
   assign last_scan = (state_q == SCAN) && (scan_idx == CW'(N_ELEM - 1));
   assign cand      = buf_mem[scan_idx];

   // Pack the searchable part of the keep list for the matcher
   always_comb begin
      keep_flat = '0;
      for (int i = 0; i < N_ELEM - 1; i++)
         keep_flat[i*DATA_W +: DATA_W] = keep_mem[i];
   end

   dedup_match #(.DATA_W(DATA_W), .N_ELEM(N_ELEM), .CW(CW)) u_match (
      .cand      (cand),
      .keep_flat (keep_flat),
      .kept_cnt  (kept_cnt),
      .hit       (hit)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= LOAD;
      else        state_q <= state_d;
   end

   // Next-state selection
   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = LOAD;
      end else begin
         case (state_q)
            LOAD:    if (in_fire && last_load)       state_d = SCAN;
            SCAN:    if (last_scan)                  state_d = EMIT;
            EMIT:    if (out_fire && st.out_last)    state_d = LOAD;
            default:                                 state_d = LOAD;
         endcase
      end
   end

   // Indices, kept count and the published unique count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_q      <= 1'b0;
         load_idx     <= '0;
         scan_idx     <= '0;
         emit_idx     <= '0;
         kept_cnt     <= '0;
         unique_count <= '0;
      end else begin
         ready_q <= 1'b1;
         if (clear) begin
            load_idx <= '0;
            scan_idx <= '0;
            emit_idx <= '0;
            kept_cnt <= '0;
         end else begin
            case (state_q)
               LOAD: if (in_fire) load_idx <= last_load ? '0 : load_idx + CW'(1);
               SCAN: begin
                  if (!hit) kept_cnt <= kept_cnt + CW'(1);
                  if (last_scan) begin
                     scan_idx     <= '0;
                     unique_count <= hit ? kept_cnt : kept_cnt + CW'(1);
                  end else begin
                     scan_idx <= scan_idx + CW'(1);
                  end
               end
               EMIT: if (out_fire) begin
                  if (st.out_last) begin
                     emit_idx <= '0;
                     kept_cnt <= '0;
                  end else begin
                     emit_idx <= emit_idx + CW'(1);
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // Frame and keep storage; contents are never exposed before being rewritten
   always_ff @(posedge clk) begin
      if (in_fire)
         buf_mem[load_idx] <= st.in_data;
      if ((state_q == SCAN) && !hit && !clear)
         keep_mem[kept_cnt] <= cand;
   end

`ifdef DEDUP_STREAM_CTRL_STATS_EN
   logic [16:0] dup_sum;
   assign dup_sum = {1'b0, dup_cnt} + 17'(N_ELEM) - 17'(unique_count);

   // Saturating per-frame statistics, bumped on each completed frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt <= '0;
         dup_cnt   <= '0;
      end else if (out_fire && st.out_last) begin
         if (frame_cnt != 16'hFFFF) frame_cnt <= frame_cnt + 16'd1;
         dup_cnt <= dup_sum[16] ? 16'hFFFF : dup_sum[15:0];
      end
   end
`endif

endmodule

// File: tb/tb_dedup_stream_ctrl.sv
// tb/tb_dedup_stream_ctrl.sv - scoreboard bench for dedup_stream_ctrl
module tb_dedup_stream_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       clear;
   logic [3:0] unique_count;
   logic       busy;
`ifdef DEDUP_STREAM_CTRL_STATS_EN
   logic [15:0] frame_cnt, dup_cnt;
`endif

   dedup_stream_ctrl_if #(.DATA_W(8)) dif ();

   dedup_stream_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .clear        (clear),
      .st           (dif),
      .unique_count (unique_count),
      .busy         (busy)
`ifdef DEDUP_STREAM_CTRL_STATS_EN
      ,
      .frame_cnt    (frame_cnt),
      .dup_cnt      (dup_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] d;
      logic       last;
      logic [3:0] ucnt;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   bit   toggle_mode = 1'b0;

   int frm [5][9] = '{
      '{15, 22, 15, 33, 22, 45, 33, 67, 15},
      '{10, 20, 30, 40, 50, 60, 70, 80, 90},
      '{ 5,  5,  5,  5,  5,  5,  5,  5,  5},
      '{ 0,  0,  1,  0,  1,  2,  2,  0, 255},
      '{ 7,  7,  7,  7,  7,  7,  7,  7,  7}
   };
   int eo [5][9] = '{
      '{15, 22, 33, 45, 67,  0,  0,  0,  0},
      '{10, 20, 30, 40, 50, 60, 70, 80, 90},
      '{ 5,  0,  0,  0,  0,  0,  0,  0,  0},
      '{ 0,  1,  2, 255, 0,  0,  0,  0,  0},
      '{ 7,  0,  0,  0,  0,  0,  0,  0,  0}
   };
   int en [5] = '{5, 9, 1, 4, 1};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // out_ready driver: steady high, or toggling every cycle
   initial begin
      dif.out_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (toggle_mode) dif.out_ready = ~dif.out_ready;
         else             dif.out_ready = 1'b1;
      end
   end

   // Monitor: pops expected beats on each accepted output and checks stall stability
   initial begin
      exp_t       e;
      bit         held = 1'b0;
      logic [7:0] hd;
      logic       hl;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (held) begin
               chk("stall_valid", 32'(dif.out_valid), 1);
               chk("stall_data", 32'(dif.out_data), 32'(hd));
               chk("stall_last", 32'(dif.out_last), 32'(hl));
            end
            if (dif.out_valid)
               chk("in_ready_in_emit", 32'(dif.in_ready), 0);
            if (dif.out_valid && dif.out_ready && !clear) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_beat: got data %0d expected no beat", dif.out_data);
               end else begin
                  e = exp_q.pop_front();
                  chk("out_data", 32'(dif.out_data), 32'(e.d));
                  chk("out_last", 32'(dif.out_last), 32'(e.last));
                  if (e.last) chk("unique_count", 32'(unique_count), 32'(e.ucnt));
               end
            end
            held = dif.out_valid && !dif.out_ready && !clear;
            hd   = dif.out_data;
            hl   = dif.out_last;
         end else begin
            held = 1'b0;
         end
      end
   end

   task automatic send_frame(input int f, input bit push, input bit lat);
      int g;
      int k;
      if (push)
         for (int j = 0; j < en[f]; j++)
            exp_q.push_back('{d: 8'(eo[f][j]), last: (j == en[f] - 1), ucnt: 4'(en[f])});
      for (int i = 0; i < 9; i++) begin
         dif.in_valid = 1'b1;
         dif.in_data  = 8'(frm[f][i]);
         g = 0;
         @(negedge clk);
         while (!dif.in_ready && g < 50) begin
            @(negedge clk);
            g++;
         end
         if (g >= 50) begin
            $display("FAIL in_ready_timeout: got 0 expected 1");
            $fatal(1, "stalled");
         end
         @(posedge clk); #1;
      end
      dif.in_valid = 1'b0;
      if (lat) begin
         k = 0;
         for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
               chk("scan_in_ready", 32'(dif.in_ready), 0);
               chk("scan_out_valid", 32'(dif.out_valid), 0);
            end
            if (dif.out_valid) begin
               k = c;
               break;
            end
         end
         chk("latency", k, 9);
      end
   endtask

   task automatic wait_drain();
      int g = 0;
      while (exp_q.size() != 0 && g < 200) begin
         @(posedge clk); #2;
         g++;
      end
      chk("drain_timeout", 32'(exp_q.size()), 0);
      chk("post_last_out_valid", 32'(dif.out_valid), 0);
      chk("post_last_in_ready", 32'(dif.in_ready), 1);
      chk("post_last_busy", 32'(busy), 0);
   endtask

   initial begin
      rst_n        = 1'b0;
      clear        = 1'b0;
      dif.in_valid = 1'b0;
      dif.in_data  = '0;
      #12;
      chk("rst_out_valid", 32'(dif.out_valid), 0);
      chk("rst_in_ready", 32'(dif.in_ready), 0);
      chk("rst_unique_count", 32'(unique_count), 0);
      chk("rst_out_data", 32'(dif.out_data), 0);
      chk("rst_out_last", 32'(dif.out_last), 0);
      chk("rst_busy", 32'(busy), 0);
      #10 rst_n = 1'b1;
      #1 chk("in_ready_before_edge", 32'(dif.in_ready), 0);
      @(posedge clk); #1;
      chk("in_ready_after_edge", 32'(dif.in_ready), 1);

      send_frame(0, 1, 1); wait_drain();
      send_frame(1, 1, 1); wait_drain();
      send_frame(2, 1, 1); wait_drain();
`ifdef DEDUP_STREAM_CTRL_STATS_EN
      chk("frame_cnt", 32'(frame_cnt), 3);
      chk("dup_cnt", 32'(dup_cnt), 12);
`endif
      toggle_mode = 1'b1;
      send_frame(3, 1, 1); wait_drain();
      toggle_mode = 1'b0;
      @(posedge clk); #1;

      // Clear during the second beat of an emitting frame
      exp_q.push_back('{d: 8'd15, last: 1'b0, ucnt: 4'd5});
      send_frame(0, 0, 1);
      @(posedge clk); #1;
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      chk("clear_out_valid", 32'(dif.out_valid), 0);
      chk("clear_unique_count", 32'(unique_count), 5);
      chk("clear_busy", 32'(busy), 0);
      chk("clear_queue", 32'(exp_q.size()), 0);
      send_frame(4, 1, 1); wait_drain();

      // Reset in the middle of SCAN
      send_frame(1, 0, 0);
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("midscan_rst_out_valid", 32'(dif.out_valid), 0);
      chk("midscan_rst_unique_count", 32'(unique_count), 0);
      chk("midscan_rst_in_ready", 32'(dif.in_ready), 0);
      #3 rst_n = 1'b1;
      #1 chk("rerel_in_ready_before_edge", 32'(dif.in_ready), 0);
      @(posedge clk); #1;
      chk("rerel_in_ready", 32'(dif.in_ready), 1);
      repeat (15) @(posedge clk);
      #1;
      send_frame(0, 1, 1); wait_drain();
`ifdef DEDUP_STREAM_CTRL_STATS_EN
      chk("frame_cnt_after_rst", 32'(frame_cnt), 1);
      chk("dup_cnt_after_rst", 32'(dup_cnt), 4);
`endif
      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
